// File: rtl/io_bridge_pkg.sv
// Shared types and helpers for the Avalon-MM to asynchronous-handshake I/O bus bridge.
// The IO_BRIDGE_TIMEOUT_EN build option is handled in io_bus_bridge_p.
package io_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic IO_RW_READ  = 1'b1;
  localparam logic IO_RW_WRITE = 1'b0;

  localparam int unsigned MAX_DATA_W = 1024;

  // Read data returned when a read is forced to complete without an acknowledge.
  function automatic logic [MAX_DATA_W-1:0] all_ones(input int unsigned w);
    logic [MAX_DATA_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAX_DATA_W; i++) begin
      if (i < w) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/io_bridge_sync2.sv
// Two-flop level synchroniser with asynchronous active-low reset.
module io_bridge_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/io_bus_bridge_p.sv
// Avalon-MM slave to external asynchronous-handshake I/O bus bridge.
// Define IO_BRIDGE_TIMEOUT_EN to build the bounded acknowledge wait and timeout_err flag.
module io_bus_bridge_p
  import io_bridge_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 255,
  parameter int BE_W        = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic [BE_W-1:0]   avs_byteenable,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_waitrequest,
  output logic [ADDR_W-1:0] io_address,
  output logic              io_bus_enable,
  output logic [BE_W-1:0]   io_byte_enable,
  output logic              io_rw,
  output logic [DATA_W-1:0] io_write_data,
  input  logic [DATA_W-1:0] io_read_data,
  input  logic              io_acknowledge,
  input  logic              io_irq,
  output logic              irq,
  output logic              timeout_err,
  input  logic              timeout_clr,
  output state_t            dbg_state
);

  localparam logic [DATA_W-1:0] FILL = DATA_W'(all_ones(DATA_W));

  // Handshake: the master holds avs_read/avs_write until it sees avs_waitrequest
  // low; that happens only in DONE, so a request is never lost or double-issued.
  state_t state_q, state_d;
  logic   req;
  logic   tmo_hit;

  logic [ADDR_W-1:0] addr_q;
  logic [BE_W-1:0]   be_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rw_q;
  logic [DATA_W-1:0] rdata_q;

  assign req       = avs_read | avs_write;
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = BUS;
      BUS:     if (io_acknowledge || tmo_hit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // io_bus_enable decodes the state register directly so reset drops it at once.
  always_comb begin
    io_bus_enable   = 1'b0;
    avs_waitrequest = req;
    case (state_q)
      BUS:     io_bus_enable   = 1'b1;
      DONE:    avs_waitrequest = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rw_q    <= IO_RW_WRITE;
    end else if (state_q == IDLE && req) begin
      addr_q  <= avs_address;
      be_q    <= avs_byteenable;
      wdata_q <= avs_writedata;
      rw_q    <= avs_write ? IO_RW_WRITE : IO_RW_READ;
    end
  end

  // tmo_hit already excludes a same-cycle acknowledge, so the ack wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q <= '0;
    end else if (state_q == BUS && rw_q == IO_RW_READ) begin
      if (io_acknowledge) rdata_q <= io_read_data;
      else if (tmo_hit)   rdata_q <= FILL;
    end
  end

  assign io_address     = addr_q;
  assign io_byte_enable = be_q;
  assign io_rw          = rw_q;
  assign io_write_data  = wdata_q;
  assign avs_readdata   = rdata_q;

`ifdef IO_BRIDGE_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE)     cnt_d = '0;
    else if (state_q == BUS) cnt_d = cnt_q + 16'd1;
  end

  assign tmo_hit = (state_q == BUS) && !io_acknowledge &&
                   (cnt_q == 16'(TIMEOUT_CYC - 1));

  always_comb begin
    err_d = err_q;
    if (tmo_hit)          err_d = 1'b1;
    else if (timeout_clr) err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign timeout_err = err_q;
`else
  logic [16:0] unused_tmo;

  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
  assign unused_tmo  = {timeout_clr, 16'(TIMEOUT_CYC)};
`endif

  io_bridge_sync2 u_irq_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d_i   (io_irq),
    .q_o   (irq)
  );

endmodule
